handshake_dispatcher: RTL



---
 rtl/async_pkg.sv | 21 ++
 rtl/handshake_dispatcher_sync.sv | 34 +++
 rtl/handshake_dispatcher.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/async_pkg.sv
// -----------------------------------------------------------------------------
// async_pkg
// Types and helpers used by the four-phase handshake dispatcher.
//   dispatch_state_t : dispatcher FSM state encoding
//   sel_width(n)     : address width needed to index n channels
// -----------------------------------------------------------------------------
package async_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        RELEASE,
        DROP
    } dispatch_state_t;

    function automatic int unsigned sel_width(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/handshake_dispatcher_sync.sv
// -----------------------------------------------------------------------------
// sync_ff
// Single-bit multi-flop synchronizer, all flops clear to 0 on reset.
// Ports:
//   clk  : destination clock
//   rst  : asynchronous active-high reset
//   i_d  : asynchronous input
//   o_q  : synchronized output (stages clk edges of latency)
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int unsigned stages = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [stages-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < int'(stages); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[stages-1];

endmodule

// File: rtl/handshake_dispatcher.sv
// -----------------------------------------------------------------------------
// handshake_dispatcher
// Routes one four-phase req/ack channel (address + payload) to exactly one of
// output_size four-phase output channels. Handshake inputs are synchronized
// into clk; every output is decoded from registered state only.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   req_in    : upstream request
//   ack_in    : upstream acknowledge
//   sel_in    : destination index, stable while req_in is high
//   data_in   : payload, stable while req_in is high
//   req_out   : per-channel downstream requests (one-hot or zero)
//   ack_out   : per-channel downstream acknowledges
//   data_out  : payload latched on IDLE exit, shared by all channels
//   busy      : FSM not in IDLE
//   err       : absorbing a request with an out-of-range sel_in
// -----------------------------------------------------------------------------
module handshake_dispatcher
    import async_pkg::*;
#(
    parameter int unsigned output_size = 8,
    parameter int unsigned data_bits   = 8,
    parameter int unsigned sel_bits    = sel_width(output_size),
    parameter int unsigned sync_stages = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_in,
    output logic                   ack_in,
    input  logic [sel_bits-1:0]    sel_in,
    input  logic [data_bits-1:0]   data_in,
    output logic [output_size-1:0] req_out,
    input  logic [output_size-1:0] ack_out,
    output logic [data_bits-1:0]   data_out,
    output logic                   busy,
    output logic                   err
);

    // One extra bit so the channel count itself is representable.
    localparam logic [sel_bits:0] NumCh = (sel_bits + 1)'(output_size);

    dispatch_state_t        r_state;
    dispatch_state_t        w_state_next;
    logic [sel_bits-1:0]    r_sel;
    logic [data_bits-1:0]   r_data;

    logic                   w_req_s;
    logic [output_size-1:0] w_ack_s;
    logic [output_size-1:0] w_sel_onehot;
    logic                   w_ack_sel;
    logic                   w_sel_valid;
    logic                   w_accept;

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    sync_ff #(
        .stages (sync_stages)
    ) u_sync_req (
        .clk (clk),
        .rst (rst),
        .i_d (req_in),
        .o_q (w_req_s)
    );

    for (genvar g = 0; g < int'(output_size); g++) begin : g_ack_sync
        sync_ff #(
            .stages (sync_stages)
        ) u_sync_ack (
            .clk (clk),
            .rst (rst),
            .i_d (ack_out[g]),
            .o_q (w_ack_s[g])
        );
    end

    // ------------------------------------------------------------------
    // Channel decode from the latched address. Out-of-range addresses
    // decode to all zeros, so they can never raise a req_out bit.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_onehot = '0;
        for (int i = 0; i < int'(output_size); i++) begin
            w_sel_onehot[i] = (r_sel == sel_bits'(i));
        end
    end

    // Only the selected channel's acknowledge is ever observed.
    assign w_ack_sel   = |(w_ack_s & w_sel_onehot);
    assign w_sel_valid = ({1'b0, sel_in} < NumCh);
    assign w_accept    = (r_state == IDLE) && w_req_s;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_req_s) begin
                    w_state_next = w_sel_valid ? REQ : DROP;
                end
            end
            REQ: begin
                if (w_ack_sel) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (!w_req_s) begin
                    w_state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!w_ack_sel) begin
                    w_state_next = IDLE;
                end
            end
            DROP: begin
                if (!w_req_s) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from registered state and address only)
    // ------------------------------------------------------------------
    always_comb begin
        req_out = '0;
        ack_in  = 1'b0;
        err     = 1'b0;
        busy    = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
            end
            REQ: begin
                req_out = w_sel_onehot;
            end
            HOLD: begin
                req_out = w_sel_onehot;
                ack_in  = 1'b1;
            end
            RELEASE: begin
                ack_in = 1'b1;
            end
            DROP: begin
                ack_in = 1'b1;
                err    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address / payload capture. sel_in and data_in are taken raw: the
    // four-phase contract keeps them stable once req_s has been seen.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel  <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_sel  <= sel_in;
            r_data <= data_in;
        end
    end

    assign data_out = r_data;

endmodule
